// File: rtl/zone_rd_scheduler_pkg.sv
// Shared types, default geometry and width helpers for the zone read scheduler.
package zone_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned ZONES_DFLT           = 360;
  localparam int unsigned BURSTS_PER_ZONE_DFLT = 477;
  localparam int unsigned TOTAL_BURSTS_DFLT    = ZONES_DFLT * BURSTS_PER_ZONE_DFLT;

  localparam int unsigned CREDIT_W   = 4;
  localparam int unsigned ZONE_IDX_W = 9;
  localparam int unsigned WD_W       = 13;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zone_rd_scheduler_if.sv
// DDR read command / read data handshake between the scheduler and the controller.
interface zone_rd_scheduler_if #(
  parameter int unsigned ADDR_W = 28
);
  logic              rd_cmd_en;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic              rd_cmd_rdy;
  logic              rd_valid;
  logic              rd_end;

  modport master (
    output rd_cmd_en, rd_cmd_addr,
    input  rd_cmd_rdy, rd_valid, rd_end
  );

  modport slave (
    input  rd_cmd_en, rd_cmd_addr,
    output rd_cmd_rdy, rd_valid, rd_end
  );
endinterface

// File: rtl/zone_rd_scheduler_credit.sv
// Outstanding-burst counter: simultaneous inc/dec cancel, decrement floors at zero.
module rd_credit_ctr #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_x1,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt
);

  logic dec_ok;

  assign dec_ok = dec && (count != '0);

  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (inc && !dec_ok)
      count_nxt = count + 1'b1;
    else if (!inc && dec_ok)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else
      count <= count_nxt;
  end

endmodule

// File: rtl/zone_rd_scheduler.sv
// Per-frame DDR read sweep for the zone max-gray receiver, credit-limited.
// Optional watchdog abort compiled in with ZONE_RD_SCHED_TIMEOUT_EN.
module zone_rd_scheduler #(
  parameter int unsigned ZONES           = zone_rd_pkg::ZONES_DFLT,
  parameter int unsigned BURSTS_PER_ZONE = zone_rd_pkg::BURSTS_PER_ZONE_DFLT,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ADDR_W          = 28,
  parameter int unsigned ADDR_STEP       = 8,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int unsigned TIMEOUT_CYC     = 4096
) (
  input  logic                              clk_x1,
  input  logic                              rst_n,
  input  logic                              frame_start,
  zone_rd_scheduler_if.master               ddr,
  output logic                              busy,
  output logic [zone_rd_pkg::ZONE_IDX_W-1:0] zone_idx,
  output logic                              zone_done,
  output logic                              frame_done,
  output logic                              err_timeout
);
  import zone_rd_pkg::*;

  localparam int unsigned TOTAL_BURSTS = ZONES * BURSTS_PER_ZONE;
  localparam int unsigned ISS_W        = cnt_w(TOTAL_BURSTS);
  localparam int unsigned BRST_W       = cnt_w(BURSTS_PER_ZONE);

  localparam logic [ISS_W-1:0]      LAST_ISS   = ISS_W'(TOTAL_BURSTS - 1);
  localparam logic [BRST_W-1:0]     LAST_BRST  = BRST_W'(BURSTS_PER_ZONE - 1);
  localparam logic [ZONE_IDX_W-1:0] LAST_ZONE  = ZONE_IDX_W'(ZONES - 1);
  localparam logic [CREDIT_W-1:0]   CREDIT_MAX = CREDIT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0]     ADDR_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]     ADDR_INC   = ADDR_W'(ADDR_STEP);

  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ISS_W-1:0]    iss_cnt_q;
  logic [BRST_W-1:0]   cmp_burst_q;
  logic [CREDIT_W-1:0] outst, outst_nxt;

  logic xfer, cmp_raw, cmp_ok, last_xfer, zone_last, frame_last, start, abort;

  assign xfer       = en_q && ddr.rd_cmd_rdy;
  assign cmp_raw    = ddr.rd_valid && ddr.rd_end;
  assign cmp_ok     = cmp_raw && (state_q != IDLE) && (outst != '0);
  assign last_xfer  = xfer && (iss_cnt_q == LAST_ISS);
  assign zone_last  = cmp_ok && (cmp_burst_q == LAST_BRST);
  assign frame_last = zone_last && (zone_idx == LAST_ZONE);
  assign start      = (state_q == IDLE) && frame_start;

  assign ddr.rd_cmd_en   = en_q;
  assign ddr.rd_cmd_addr = addr_q;
  assign busy            = (state_q != IDLE);

  rd_credit_ctr #(
    .CNT_W (CREDIT_W)
  ) u_credit (
    .clk_x1    (clk_x1),
    .rst_n     (rst_n),
    .clr       (abort),
    .inc       (xfer),
    .dec       (cmp_raw && (state_q != IDLE)),
    .count     (outst),
    .count_nxt (outst_nxt)
  );

`ifdef ZONE_RD_SCHED_TIMEOUT_EN
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign abort       = (wd_q == WD_W'(TIMEOUT_CYC));
  assign err_timeout = err_q;

  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (abort)
        err_q <= 1'b1;
      if ((state_q == IDLE) || cmp_raw || abort)
        wd_q <= '0;
      else if (outst != '0)
        wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign abort       = 1'b0;
  assign err_timeout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = ISSUE;
      ISSUE:   if (last_xfer)   state_d = DRAIN;
      DRAIN:   if (frame_last)  state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
    if (abort)
      state_d = IDLE;
  end

  // Enable is registered from the post-edge credit count, so once raised it can
  // only fall on the transfer that consumes the last credit or the last burst.
  assign en_d = (state_q == ISSUE) && !last_xfer && !abort && (outst_nxt < CREDIT_MAX);

  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      addr_q      <= ADDR_BASE;
      iss_cnt_q   <= '0;
      cmp_burst_q <= '0;
      zone_idx    <= '0;
      zone_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      zone_done  <= zone_last && !abort;
      frame_done <= frame_last && !abort;
      if (start || abort) begin
        addr_q      <= ADDR_BASE;
        iss_cnt_q   <= '0;
        cmp_burst_q <= '0;
        zone_idx    <= '0;
      end else begin
        if (xfer) begin
          addr_q    <= addr_q + ADDR_INC;
          iss_cnt_q <= iss_cnt_q + 1'b1;
        end
        if (cmp_ok) begin
          if (zone_last) begin
            cmp_burst_q <= '0;
            zone_idx    <= frame_last ? '0 : zone_idx + 1'b1;
          end else begin
            cmp_burst_q <= cmp_burst_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_zone_rd_scheduler.sv
// Directed bench: dut_a (2x3 bursts) for sweep timing/watchdog, dut_b (3x4, 6-bit addr) for credits/stall/wrap.
module tb_zone_rd_scheduler;

  logic       clk_x1 = 1'b0;
  logic       rst_n;
  logic       fs_a, fs_b;
  logic       busy_a, zd_a, fd_a, err_a;
  logic       busy_b, zd_b, fd_b, err_b;
  logic [8:0] zidx_a, zidx_b;

  int n_checks = 0;
  int n_errors = 0;
  int nxt_b    = 0;
  int zd_cnt_b = 0;
  int fd_cnt_b = 0;

  zone_rd_scheduler_if #(.ADDR_W(28)) ifa ();
  zone_rd_scheduler_if #(.ADDR_W(6))  ifb ();

  zone_rd_scheduler #(
    .ZONES(2), .BURSTS_PER_ZONE(3), .MAX_OUTSTANDING(8), .ADDR_W(28),
    .ADDR_STEP(8), .BASE_ADDR(0), .TIMEOUT_CYC(16)
  ) dut_a (
    .clk_x1(clk_x1), .rst_n(rst_n), .frame_start(fs_a), .ddr(ifa.master),
    .busy(busy_a), .zone_idx(zidx_a), .zone_done(zd_a), .frame_done(fd_a), .err_timeout(err_a)
  );

  zone_rd_scheduler #(
    .ZONES(3), .BURSTS_PER_ZONE(4), .MAX_OUTSTANDING(8), .ADDR_W(6),
    .ADDR_STEP(8), .BASE_ADDR(0), .TIMEOUT_CYC(4096)
  ) dut_b (
    .clk_x1(clk_x1), .rst_n(rst_n), .frame_start(fs_b), .ddr(ifb.master),
    .busy(busy_b), .zone_idx(zidx_b), .zone_done(zd_b), .frame_done(fd_b), .err_timeout(err_b)
  );

  always #5 clk_x1 = ~clk_x1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One dut_b cycle: drive at the falling edge, log the transfer the next rising edge takes.
  task automatic cyc_b(input bit rdy, input bit cmp);
    zd_cnt_b += int'(zd_b);
    fd_cnt_b += int'(fd_b);
    ifb.rd_cmd_rdy = rdy;
    ifb.rd_valid   = cmp;
    ifb.rd_end     = cmp;
    if (ifb.rd_cmd_en && rdy) begin
      chk("b_addr", 32'(ifb.rd_cmd_addr), 32'((nxt_b * 8) % 64));
      nxt_b++;
    end
    @(negedge clk_x1);
  endtask

  // Full dut_a sweep: each transfer gets a data beat 3 cycles later and rd_end 4 cycles later.
  task automatic run_frame_a(input string tag);
    bit endp[64];
    bit beat[64];
    int n_x = 0, sent = 0, fd_seen = 0, fd_c = -1, zd_n = 0;
    int zd_at[2] = '{-1, -1};
    logic prev_busy;
    ifa.rd_cmd_rdy = 1'b1;
    fs_a = 1'b1;
    @(negedge clk_x1);
    fs_a = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy_a), 32'd1);
    chk({tag, "_en_latency"}, 32'(ifa.rd_cmd_en), 32'd0);
    prev_busy = busy_a;
    for (int c = 0; c < 60; c++) begin
      if (zd_a) begin
        if (zd_n < 2) zd_at[zd_n] = sent;
        zd_n++;
        chk({tag, "_zidx_at_zd"}, 32'(zidx_a), (zd_n == 1) ? 32'd1 : 32'd0);
      end
      if (fd_a) begin
        fd_seen++;
        fd_c = c;
        chk({tag, "_busy_fall_with_fd"}, 32'(busy_a), 32'd0);
        chk({tag, "_busy_before_fd"}, 32'(prev_busy), 32'd1);
        chk({tag, "_fd_after_cmp"}, 32'(sent), 32'd6);
      end
      if (fd_c >= 0 && c >= fd_c + 3) break;
      if (ifa.rd_cmd_en && ifa.rd_cmd_rdy) begin
        chk({tag, "_addr"}, 32'(ifa.rd_cmd_addr), 32'(n_x * 8));
        n_x++;
        beat[c + 3] = 1'b1;
        endp[c + 4] = 1'b1;
      end
      ifa.rd_valid = beat[c] | endp[c];
      ifa.rd_end   = endp[c];
      sent += int'(endp[c]);
      prev_busy = busy_a;
      @(negedge clk_x1);
    end
    ifa.rd_valid = 1'b0;
    ifa.rd_end   = 1'b0;
    chk({tag, "_n_xfer"}, 32'(n_x), 32'd6);
    chk({tag, "_n_zd"}, 32'(zd_n), 32'd2);
    chk({tag, "_zd0_at"}, 32'(zd_at[0]), 32'd3);
    chk({tag, "_zd1_at"}, 32'(zd_at[1]), 32'd6);
    chk({tag, "_n_fd"}, 32'(fd_seen), 32'd1);
    chk({tag, "_end_zidx"}, 32'(zidx_a), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    fs_a = 1'b0; fs_b = 1'b0;
    ifa.rd_cmd_rdy = 1'b0; ifa.rd_valid = 1'b0; ifa.rd_end = 1'b0;
    ifb.rd_cmd_rdy = 1'b0; ifb.rd_valid = 1'b0; ifb.rd_end = 1'b0;
    repeat (3) @(negedge clk_x1);

    chk("rst_en_a",   32'(ifa.rd_cmd_en),   32'd0);
    chk("rst_addr_a", 32'(ifa.rd_cmd_addr), 32'd0);
    chk("rst_busy_a", 32'(busy_a),          32'd0);
    chk("rst_zidx_a", 32'(zidx_a),          32'd0);
    chk("rst_zd_a",   32'(zd_a),            32'd0);
    chk("rst_fd_a",   32'(fd_a),            32'd0);
    chk("rst_err_a",  32'(err_a),           32'd0);
    chk("rst_en_b",   32'(ifb.rd_cmd_en),   32'd0);
    chk("rst_busy_b", 32'(busy_b),          32'd0);
    rst_n = 1'b1;
    @(negedge clk_x1);

    run_frame_a("fa1");

    // Spurious completion while idle must not move any counter.
    ifa.rd_valid = 1'b1; ifa.rd_end = 1'b1;
    @(negedge clk_x1);
    ifa.rd_valid = 1'b0; ifa.rd_end = 1'b0;
    @(negedge clk_x1);
    chk("idle_cmp_zd",   32'(zd_a),          32'd0);
    chk("idle_cmp_fd",   32'(fd_a),          32'd0);
    chk("idle_cmp_en",   32'(ifa.rd_cmd_en), 32'd0);
    chk("idle_cmp_busy", 32'(busy_a),        32'd0);
    chk("idle_cmp_zidx", 32'(zidx_a),        32'd0);
    run_frame_a("fa2");

    // dut_b: stall, credit limit, refill, simultaneous xfer/cmp, DRAIN, wrap.
    fs_b = 1'b1;
    cyc_b(1'b1, 1'b0);
    fs_b = 1'b0;
    chk("b_busy_rise", 32'(busy_b), 32'd1);
    chk("b_en_lat1",   32'(ifb.rd_cmd_en), 32'd0);
    cyc_b(1'b1, 1'b0);
    chk("b_first_en",   32'(ifb.rd_cmd_en),   32'd1);
    chk("b_first_addr", 32'(ifb.rd_cmd_addr), 32'd0);
    for (int i = 0; i < 3; i++) cyc_b(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc_b(1'b0, 1'b0);
      chk("b_stall_en",   32'(ifb.rd_cmd_en),   32'd1);
      chk("b_stall_addr", 32'(ifb.rd_cmd_addr), 32'd24);
    end
    chk("b_n_before_fill", 32'(nxt_b), 32'd3);
    for (int i = 0; i < 20 && ifb.rd_cmd_en; i++) cyc_b(1'b1, 1'b0);
    chk("b_credit_n", 32'(nxt_b), 32'd8);
    chk("b_credit_en", 32'(ifb.rd_cmd_en), 32'd0);
    for (int i = 0; i < 3; i++) cyc_b(1'b1, 1'b0);
    chk("b_credit_hold_n", 32'(nxt_b), 32'd8);
    chk("b_credit_hold_en", 32'(ifb.rd_cmd_en), 32'd0);
    cyc_b(1'b1, 1'b1);
    chk("b_refill_en", 32'(ifb.rd_cmd_en), 32'd1);
    cyc_b(1'b1, 1'b0);
    cyc_b(1'b1, 1'b0);
    cyc_b(1'b1, 1'b0);
    chk("b_refill_n", 32'(nxt_b), 32'd9);
    chk("b_refill_en0", 32'(ifb.rd_cmd_en), 32'd0);
    cyc_b(1'b1, 1'b1);
    cyc_b(1'b1, 1'b1);
    chk("b_sim_n", 32'(nxt_b), 32'd10);
    chk("b_sim_en", 32'(ifb.rd_cmd_en), 32'd1);
    cyc_b(1'b0, 1'b0);
    chk("b_sim_en_hold", 32'(ifb.rd_cmd_en), 32'd1);
    cyc_b(1'b1, 1'b0);
    chk("b_sim_full_n", 32'(nxt_b), 32'd11);
    chk("b_sim_full_en", 32'(ifb.rd_cmd_en), 32'd0);
    chk("b_no_zd_yet", 32'(zd_cnt_b), 32'd0);
    cyc_b(1'b1, 1'b1);
    chk("b_zd0", 32'(zd_b), 32'd1);
    chk("b_zidx1", 32'(zidx_b), 32'd1);
    cyc_b(1'b1, 1'b0);
    chk("b_last_n", 32'(nxt_b), 32'd12);
    fs_b = 1'b1;
    cyc_b(1'b1, 1'b0);
    fs_b = 1'b0;
    cyc_b(1'b1, 1'b0);
    cyc_b(1'b1, 1'b0);
    chk("b_drain_fs_busy", 32'(busy_b),        32'd1);
    chk("b_drain_fs_en",   32'(ifb.rd_cmd_en), 32'd0);
    chk("b_drain_fs_n",    32'(nxt_b),         32'd12);
    chk("b_drain_fs_zidx", 32'(zidx_b),        32'd1);
    for (int i = 0; i < 7; i++) cyc_b(1'b0, 1'b1);
    chk("b_drain_busy", 32'(busy_b), 32'd1);
    chk("b_drain_fd",   32'(fd_b),   32'd0);
    chk("b_drain_zidx", 32'(zidx_b), 32'd2);
    cyc_b(1'b0, 1'b1);
    chk("b_fd",       32'(fd_b),   32'd1);
    chk("b_fd_busy",  32'(busy_b), 32'd0);
    chk("b_fd_zd",    32'(zd_b),   32'd1);
    chk("b_fd_zidx",  32'(zidx_b), 32'd0);
    cyc_b(1'b0, 1'b0);
    chk("b_fd_pulse", 32'(fd_b), 32'd0);
    chk("b_zd_total", 32'(zd_cnt_b), 32'd3);
    chk("b_fd_total", 32'(fd_cnt_b), 32'd1);

`ifdef ZONE_RD_SCHED_TIMEOUT_EN
    // Hang dut_a after its second transfer and wait for the watchdog.
    ifa.rd_cmd_rdy = 1'b1;
    fs_a = 1'b1;
    @(negedge clk_x1);
    fs_a = 1'b0;
    @(negedge clk_x1);
    chk("to_en0", 32'(ifa.rd_cmd_en), 32'd1);
    @(negedge clk_x1);
    chk("to_addr1", 32'(ifa.rd_cmd_addr), 32'd8);
    @(negedge clk_x1);
    ifa.rd_cmd_rdy = 1'b0;
    k = 0;
    while (!err_a && k < 40) begin
      @(negedge clk_x1);
      k++;
    end
    chk("to_delay", 32'(k), 32'd16);
    chk("to_err",   32'(err_a), 32'd1);
    chk("to_busy",  32'(busy_a), 32'd0);
    chk("to_fd",    32'(fd_a), 32'd0);
    chk("to_en",    32'(ifa.rd_cmd_en), 32'd0);
    repeat (3) @(negedge clk_x1);
    chk("to_sticky", 32'(err_a), 32'd1);
`else
    k = 0;
    chk("no_to_err_a", 32'(err_a), 32'd0);
    chk("no_to_err_b", 32'(err_b), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
